// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the instruction/data memory
//                port arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam logic [3:0] BE_ALL = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/arb_lat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : arb_lat_counter
//  Description : Loadable read-latency down-counter. Loading arms it with
//                MEM_LAT-1; o_done pulses for one cycle when it reaches zero,
//                which is exactly MEM_LAT cycles after the load cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module arb_lat_counter #(
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    output logic o_done
);

    localparam int              CW       = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0]   LOAD_VAL = CW'(MEM_LAT - 1);

    logic [CW-1:0] r_cnt;
    logic          r_busy;

    // Count down while armed; a new load always takes precedence over retiring
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_load) begin
            r_cnt  <= LOAD_VAL;
            r_busy <= 1'b1;
        end else if (o_done) begin
            r_busy <= 1'b0;
        end else if (r_busy) begin
            r_cnt  <= r_cnt - 1'b1;
        end
    end

    assign o_done = r_busy && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-port synchronous memory between the fetch
//                stage and the data stage. Data wins conflicts unless fetch
//                has lost STARVE_LIMIT times in a row. One read in flight;
//                the response cycle doubles as an idle cycle so reads can be
//                issued back to back every MEM_LAT cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT      = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_kill,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata
);

    localparam int            SW        = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    owner_t        r_owner;
    logic [SW-1:0] r_starve;
    logic          r_kill;

    logic w_lat_done;
    logic w_resp;
    logic w_free;
    logic w_pick_d;
    logic w_if_gnt;
    logic w_d_gnt;
    logic w_rd_gnt;

    arb_lat_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_lat (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_rd_gnt),
        .o_done (w_lat_done)
    );

    // Gating with rst_n keeps every output quiet while reset is asserted
    assign w_resp   = rst_n && (r_state == ARB_WAIT) && w_lat_done;
    assign w_free   = rst_n && ((r_state == ARB_IDLE) || w_resp);
    assign w_pick_d = d_req && !(if_req && (r_starve == STARVE_MAX));
    assign w_d_gnt  = w_free && w_pick_d;
    assign w_if_gnt = w_free && if_req && !w_pick_d;
    assign w_rd_gnt = w_if_gnt || (w_d_gnt && !d_we);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and memory/handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        if_gnt      = w_if_gnt;
        d_gnt       = w_d_gnt;
        mem_en      = w_if_gnt || w_d_gnt;
        mem_we      = w_d_gnt && d_we;
        mem_addr    = 32'h0;
        mem_wdata   = 32'h0;
        mem_be      = 4'h0;
        if (w_rd_gnt) begin
            w_state_nxt = ARB_WAIT;
        end else if (w_resp) begin
            w_state_nxt = ARB_IDLE;
        end
        if (w_d_gnt) begin
            mem_addr = d_addr;
            if (d_we) begin
                mem_wdata = d_wdata;
                mem_be    = d_be;
            end else begin
                mem_be    = BE_ALL;
            end
        end else if (w_if_gnt) begin
            mem_addr = if_addr;
            mem_be   = BE_ALL;
        end
    end

    // Owner, starvation counter and fetch-kill flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner  <= OWN_IF;
            r_starve <= '0;
            r_kill   <= 1'b0;
        end else begin
            if (w_rd_gnt) begin
                r_owner <= w_d_gnt ? OWN_D : OWN_IF;
            end
            if (w_if_gnt) begin
                r_starve <= '0;
            end else if (w_d_gnt && if_req && (r_starve != STARVE_MAX)) begin
                r_starve <= r_starve + 1'b1;
            end
            // A kill seen in the grant cycle applies to the new fetch
            if (w_if_gnt) begin
                r_kill <= if_kill;
            end else if (w_resp && (r_owner == OWN_IF)) begin
                r_kill <= 1'b0;
            end else if ((r_state == ARB_WAIT) && (r_owner == OWN_IF) && if_kill) begin
                r_kill <= 1'b1;
            end
        end
    end

    // Response steering: the owner sees data exactly once, unless killed
    always_comb begin
        if_rvalid = w_resp && (r_owner == OWN_IF) && !r_kill && !if_kill;
        d_rvalid  = w_resp && (r_owner == OWN_D);
        if_rdata  = if_rvalid ? mem_rdata : 32'h0;
        d_rdata   = d_rvalid  ? mem_rdata : 32'h0;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter (MEM_LAT=2,
//                STARVE_LIMIT=3) with a behavioural two-cycle memory.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    typedef logic [137:0] bund_t;

    typedef struct {
        string       name;
        logic        rst_n;
        logic        if_req;
        logic [31:0] if_addr;
        logic        if_kill;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [3:0]  d_be;
        bund_t       exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        if_kill = 1'b0;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic [3:0]  d_be = 4'h0;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    vec_t vecs[$];

    mem_port_arbiter #(
        .MEM_LAT      (2),
        .STARVE_LIMIT (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_kill   (if_kill),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural memory: byte-enabled writes, reads returned two cycles later
    logic [31:0] mem [logic [31:0]];
    logic [31:0] pipe0 = 32'h0;
    logic [31:0] pipe1 = 32'h0;
    assign mem_rdata = pipe1;

    always @(posedge clk) begin
        logic [31:0] w;
        if (mem_en && mem_we) begin
            w = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            end
            mem[mem_addr] = w;
        end
        pipe1 <= pipe0;
        pipe0 <= (mem_en && !mem_we) ? (mem.exists(mem_addr) ? mem[mem_addr] : 32'h0) : 32'h0;
    end

    function automatic bund_t act_bundle();
        return {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
                mem_en, mem_we, mem_addr, mem_wdata, mem_be};
    endfunction

    function automatic bund_t mk_exp(logic eig, logic eirv, logic [31:0] eird,
                                     logic edg, logic edrv, logic [31:0] edrd,
                                     logic een, logic ewe, logic [31:0] ea,
                                     logic [31:0] ewd, logic [3:0] ebe);
        return {eig, eirv, eird, edg, edrv, edrd, een, ewe, ea, ewd, ebe};
    endfunction

    task automatic add(string nm, logic r, logic ifr, logic [31:0] ifa, logic ifk,
                       logic dr, logic dwe, logic [31:0] da, logic [31:0] dwd,
                       logic [3:0] dbe, bund_t e);
        vec_t v;
        v.name = nm; v.rst_n = r; v.if_req = ifr; v.if_addr = ifa; v.if_kill = ifk;
        v.d_req = dr; v.d_we = dwe; v.d_addr = da; v.d_wdata = dwd; v.d_be = dbe;
        v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(string nm, bund_t act, bund_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        rst_n   = v.rst_n;
        if_req  = v.if_req;
        if_addr = v.if_addr;
        if_kill = v.if_kill;
        d_req   = v.d_req;
        d_we    = v.d_we;
        d_addr  = v.d_addr;
        d_wdata = v.d_wdata;
        d_be    = v.d_be;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_kill = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
    endtask

    bund_t Z;
    logic  exp_d [8];

    initial begin
        int ng;
        int last;
        mem[32'h100]  = 32'h00500093;
        mem[32'h104]  = 32'h11111111;
        mem[32'h3000] = 32'hCAFEF00D;
        Z = '0;

        // Reset holds everything low even with both requests pending
        add("rst_hold0",      0,1,32'h104,0, 1,0,32'h3000,0,4'h0, Z);
        add("rst_hold1",      0,1,32'h104,0, 1,0,32'h3000,0,4'h0, Z);
        add("rst_rel_dgnt",   1,1,32'h104,0, 1,0,32'h3000,0,4'h0, mk_exp(0,0,0, 1,0,0, 1,0,32'h3000,0,4'hF));
        add("wait_d",         1,1,32'h104,0, 0,0,0,0,4'h0, Z);
        add("resp_d_gnt_if",  1,1,32'h104,0, 0,0,0,0,4'h0, mk_exp(1,0,0, 0,1,32'hCAFEF00D, 1,0,32'h104,0,4'hF));
        add("wait_if",        1,0,0,0, 0,0,0,0,4'h0, Z);
        add("resp_if",        1,0,0,0, 0,0,0,0,4'h0, mk_exp(0,1,32'h11111111, 0,0,0, 0,0,0,0,4'h0));
        add("idle",           1,0,0,0, 0,0,0,0,4'h0, Z);
        // Lone fetch
        add("lone_fetch_gnt", 1,1,32'h100,0, 0,0,0,0,4'h0, mk_exp(1,0,0, 0,0,0, 1,0,32'h100,0,4'hF));
        add("lone_fetch_wait",1,0,0,0, 0,0,0,0,4'h0, Z);
        add("lone_fetch_rv",  1,0,0,0, 0,0,0,0,4'h0, mk_exp(0,1,32'h00500093, 0,0,0, 0,0,0,0,4'h0));
        // Store then load of the same word
        add("store_gnt",      1,0,0,0, 1,1,32'h2000,32'hAABBCCDD,4'h3, mk_exp(0,0,0, 1,0,0, 1,1,32'h2000,32'hAABBCCDD,4'h3));
        add("load_after_st",  1,0,0,0, 1,0,32'h2000,0,4'h0, mk_exp(0,0,0, 1,0,0, 1,0,32'h2000,0,4'hF));
        add("load_wait",      1,0,0,0, 0,0,0,0,4'h0, Z);
        add("load_rv",        1,0,0,0, 0,0,0,0,4'h0, mk_exp(0,0,0, 0,1,32'h0000CCDD, 0,0,0,0,4'h0));
        // Killed fetch; port stays busy for the full latency
        add("kill_fetch_gnt", 1,1,32'h100,0, 0,0,0,0,4'h0, mk_exp(1,0,0, 0,0,0, 1,0,32'h100,0,4'hF));
        add("kill_wait",      1,0,0,1, 0,0,0,0,4'h0, Z);
        add("kill_resp_regnt",1,1,32'h104,0, 0,0,0,0,4'h0, mk_exp(1,0,0, 0,0,0, 1,0,32'h104,0,4'hF));
        add("regnt_wait",     1,0,0,0, 0,0,0,0,4'h0, Z);
        add("after_kill_rv",  1,0,0,0, 0,0,0,0,4'h0, mk_exp(0,1,32'h11111111, 0,0,0, 0,0,0,0,4'h0));
        // Kill without a fetch owner has no effect
        add("kill_nf_gnt",    1,0,0,1, 1,0,32'h3000,0,4'h0, mk_exp(0,0,0, 1,0,0, 1,0,32'h3000,0,4'hF));
        add("kill_nf_wait",   1,0,0,1, 0,0,0,0,4'h0, Z);
        add("kill_nf_rv",     1,0,0,1, 0,0,0,0,4'h0, mk_exp(0,0,0, 0,1,32'hCAFEF00D, 0,0,0,0,4'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check(vecs[i].name, act_bundle(), vecs[i].exp);
        end

        // Both requesters held high: D,D,D,IF then the count restarts
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        @(negedge clk);
        idle_inputs();
        if_req = 1'b1; if_addr = 32'h100;
        d_req  = 1'b1; d_addr  = 32'h3000;
        ng = 0;
        last = -1;
        for (int cyc = 0; cyc < 40 && ng < 8; cyc++) begin
            if (cyc > 0) @(negedge clk);
            #1;
            if (if_gnt || d_gnt) begin
                check("starve_order", bund_t'({if_gnt, d_gnt}), bund_t'({~exp_d[ng], exp_d[ng]}));
                if (ng > 0) check("starve_gap", bund_t'(cyc - last), bund_t'(2));
                last = cyc;
                ng++;
            end
        end
        if (ng < 8) begin
            checks++;
            failures++;
            $display("FAIL starve_timeout grants=%0d required=8", ng);
        end
        @(negedge clk);
        idle_inputs();
        repeat (3) @(negedge clk);

        // Reset while a load is outstanding drops it
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
        #1;
        check("rst_mid_gnt", bund_t'(d_gnt), bund_t'(1));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_zero", act_bundle(), Z);
        #1 rst_n = 1'b1;
        d_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check("rst_mid_no_rv", bund_t'({d_rvalid, if_rvalid}), bund_t'(0));
        end
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100;
        #1;
        check("rst_mid_idle_gnt", bund_t'(if_gnt), bund_t'(1));
        @(negedge clk);
        idle_inputs();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
